// File: rtl/line_memory.sv
// Whole-line main-memory model with a fixed request latency.
// One request in flight; reads return a registered line with a one-cycle valid pulse.
module line_memory #(
   parameter int BLOCK_SIZE = 16,
   parameter int NUM_BLOCKS = 1024,
   parameter int DELAY      = 50
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      is_input_valid,
   input  logic [31:0]               addr,
   input  logic                      mem_read,
   input  logic                      mem_write,
   input  logic [BLOCK_SIZE*8-1:0]   din,
   output logic                      is_output_valid,
   output logic [BLOCK_SIZE*8-1:0]   dout,
   output logic                      mem_ready,
   output logic [1:0]                o_dbg_state
);

   localparam int LINE_W = BLOCK_SIZE * 8;
   localparam int IDX_W  = $clog2(NUM_BLOCKS);
   localparam int CNT_W  = $clog2(DELAY) + 1;

   // Handshake: a request is taken on a rising edge where is_input_valid and
   // mem_ready are both high and exactly one of mem_read/mem_write is set.
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_BUSY    = 2'd1,
      S_RESPOND = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [IDX_W-1:0]   r_idx;
   logic               r_is_read;
   logic [LINE_W-1:0]  r_din;
   logic [LINE_W-1:0]  r_mem [NUM_BLOCKS];

   logic               w_accept;
   logic               w_done;
   logic               w_unused_addr;

   // Upper address bits alias onto the same lines.
   assign w_unused_addr = ^addr[31:IDX_W];

   assign w_accept    = is_input_valid && (r_state == S_IDLE) && (mem_read ^ mem_write);
   assign w_done      = (r_state == S_BUSY) && (r_cnt == '0);
   assign o_dbg_state = r_state;

   always_comb begin
      w_state_nxt     = r_state;
      mem_ready       = 1'b0;
      is_output_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            mem_ready = 1'b1;
            if (w_accept) w_state_nxt = S_BUSY;
         end
         S_BUSY: begin
            if (r_cnt == '0) w_state_nxt = S_RESPOND;
         end
         S_RESPOND: begin
            is_output_valid = r_is_read;
            w_state_nxt     = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_idx     <= '0;
         r_is_read <= 1'b0;
         r_din     <= '0;
         dout      <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_cnt     <= CNT_W'(DELAY - 1);
            r_idx     <= addr[IDX_W-1:0];
            r_is_read <= mem_read;
            r_din     <= din;
         end else if ((r_state == S_BUSY) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
         if (w_done && r_is_read) dout <= r_mem[r_idx];
      end
   end

   // The array has no reset; a reset mid-request returns to IDLE, so w_done never fires.
   always_ff @(posedge clk) begin
      if (w_done && !r_is_read) r_mem[r_idx] <= r_din;
   end

endmodule

// File: tb/tb_line_memory.sv
// Directed bench for line_memory with a transaction-timing reference model
// compared on every falling edge, plus hand-computed literal checks.
module tb_line_memory;

  localparam int BLOCK_SIZE = 16;
  localparam int NUM_BLOCKS = 1024;
  localparam int DELAY      = 4;
  localparam int W          = BLOCK_SIZE * 8;

  localparam logic [W-1:0] DATA_A = 128'hDEADBEEF_00000001_CAFEF00D_12345678;
  localparam logic [W-1:0] DATA_B = 128'h01234567_89ABCDEF_0F1E2D3C_4B5A6978;

  logic         clk = 1'b0;
  logic         reset;
  logic         is_input_valid;
  logic [31:0]  addr;
  logic         mem_read;
  logic         mem_write;
  logic [W-1:0] din;
  logic         is_output_valid;
  logic [W-1:0] dout;
  logic         mem_ready;
  logic [1:0]   dbg_state;

  int vectors   = 0;
  int miscompares = 0;
  bit started   = 1'b0;

  line_memory #(
    .BLOCK_SIZE(BLOCK_SIZE),
    .NUM_BLOCKS(NUM_BLOCKS),
    .DELAY(DELAY)
  ) dut (
    .clk(clk),
    .reset(reset),
    .is_input_valid(is_input_valid),
    .addr(addr),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .din(din),
    .is_output_valid(is_output_valid),
    .dout(dout),
    .mem_ready(mem_ready),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Timing from the accept edge T: busy through edge T+DELAY, read data at T+DELAY.
  logic [W-1:0] m_mem [int];
  int           e      = 0;
  bit           active = 1'b0;
  int           m_t    = 0;
  bit           m_rd   = 1'b0;
  int           m_idx  = 0;
  logic [W-1:0] m_data = '0;
  bit           exp_ready = 1'b1;
  bit           exp_valid = 1'b0;
  logic [W-1:0] exp_dout  = '0;

  always @(negedge reset) begin
    active    = 1'b0;
    exp_ready = 1'b1;
    exp_valid = 1'b0;
    exp_dout  = '0;
  end

  always @(posedge clk) begin
    bit rdy_before;
    rdy_before = !(active && e >= m_t && e <= m_t + DELAY);
    e = e + 1;
    if (reset) begin
      if (active && e == m_t + DELAY) begin
        if (m_rd) exp_dout = m_mem.exists(m_idx) ? m_mem[m_idx] : 'x;
        else      m_mem[m_idx] = m_data;
      end
      if (rdy_before && is_input_valid && (mem_read ^ mem_write)) begin
        active = 1'b1;
        m_t    = e;
        m_rd   = mem_read;
        m_idx  = int'(addr) & (NUM_BLOCKS - 1);
        m_data = din;
      end
    end
    exp_ready = !(active && e >= m_t && e <= m_t + DELAY);
    exp_valid = active && m_rd && (e == m_t + DELAY);
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      check("model_ready", W'(mem_ready), W'(exp_ready));
      check("model_valid", W'(is_output_valid), W'(exp_valid));
      check("model_dout", dout, exp_dout);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic req(input bit rd, input bit wr, input logic [31:0] a, input logic [W-1:0] d);
    int n = 0;
    while (!mem_ready && n < 40) begin
      idle(1);
      n++;
    end
    if (n >= 40) begin
      check("req_timeout", W'(mem_ready), W'(1));
    end else begin
      is_input_valid = 1'b1;
      mem_read  = rd;
      mem_write = wr;
      addr      = a;
      din       = d;
      idle(1);
      is_input_valid = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    is_input_valid = 1'b0;
    addr = '0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    din = '0;
    #1 reset = 1'b0;
    started = 1'b1;
    idle(2);
    check("rst_ready", W'(mem_ready), W'(1));
    check("rst_valid", W'(is_output_valid), W'(0));
    check("rst_dout", dout, '0);
    reset = 1'b1;
    idle(1);

    // Write line 5; ready low after edges T..T+4.
    req(1'b0, 1'b1, 32'd5, DATA_A);
    check("wr_busy_t0", W'(mem_ready), W'(0));
    idle(4);
    check("wr_busy_t4", W'(mem_ready), W'(0));
    check("wr_no_valid", W'(is_output_valid), W'(0));
    idle(1);
    check("wr_ready_t5", W'(mem_ready), W'(1));

    // Read line 5; pulse only after edge T+4.
    req(1'b1, 1'b0, 32'd5, '0);
    idle(3);
    check("rd_valid_t3", W'(is_output_valid), W'(0));
    idle(1);
    check("rd_valid_t4", W'(is_output_valid), W'(1));
    check("rd_dout_t4", dout, DATA_A);
    idle(1);
    check("rd_valid_t5", W'(is_output_valid), W'(0));
    check("rd_ready_t5", W'(mem_ready), W'(1));
    idle(2);
    check("rd_dout_hold", dout, DATA_A);

    // Line 7, then alias of line 5.
    req(1'b0, 1'b1, 32'd7, DATA_B);
    req(1'b1, 1'b0, 32'd7, '0);
    idle(5);
    check("rd7_dout", dout, DATA_B);
    req(1'b1, 1'b0, 32'd1029, '0);
    idle(5);
    check("alias_dout", dout, DATA_A);

    // Write to 7 while busy must be ignored.
    req(1'b1, 1'b0, 32'd5, '0);
    is_input_valid = 1'b1;
    mem_write = 1'b1;
    addr = 32'd7;
    din = W'(128'h77);
    idle(3);
    is_input_valid = 1'b0;
    mem_write = 1'b0;
    idle(3);
    req(1'b1, 1'b0, 32'd7, '0);
    idle(5);
    check("busy_ignored", dout, DATA_B);

    // Both op bits set in IDLE: no accept.
    is_input_valid = 1'b1;
    mem_read = 1'b1;
    mem_write = 1'b1;
    addr = 32'd5;
    din = W'(128'h99);
    idle(1);
    check("both_ready1", W'(mem_ready), W'(1));
    idle(1);
    check("both_ready2", W'(mem_ready), W'(1));
    is_input_valid = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    idle(1);

    // Abort a write with reset after edge T+2.
    req(1'b0, 1'b1, 32'd5, W'(128'h1));
    idle(2);
    reset = 1'b0;
    #1;
    check("abort_ready", W'(mem_ready), W'(1));
    check("abort_valid", W'(is_output_valid), W'(0));
    check("abort_dout", dout, '0);
    idle(2);
    reset = 1'b1;
    idle(1);
    req(1'b1, 1'b0, 32'd5, '0);
    idle(5);
    check("abort_kept", dout, DATA_A);

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
